// File: rtl/flit_tx_arbiter.sv
// Round-robin, packet-locking arbiter onto one outgoing flit link.
// A head flit locks the link to its requester until the tail, or until the lock times out.
module flit_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FLIT_WIDTH = 128,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*FLIT_WIDTH-1:0] req_flit,
    input  logic [NUM_REQ-1:0]            req_vld,
    output logic [NUM_REQ-1:0]            req_rdy,
    output logic [FLIT_WIDTH-1:0]         flit_tx,
    output logic                          flit_tx_vld,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          proto_err,
    output logic                          lock_timeout
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int TW  = $clog2(TIMEOUT + 1);

    localparam logic [1:0] FT_HEAD   = 2'b00;
    localparam logic [1:0] FT_TAIL   = 2'b10;
    localparam logic [1:0] FT_SINGLE = 2'b11;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t               state;
    logic [IDW-1:0]       ptr;
    logic [IDW-1:0]       own;
    logic [TW-1:0]        tcnt;

    logic                 idle_hit;
    logic [IDW-1:0]       idle_sel;
    logic [IDW-1:0]       sel;
    logic                 xfer;
    logic [FLIT_WIDTH-1:0] flit_sel;
    logic [1:0]           ftype;

    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
        return (i == IDW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    // Scan from the far end back toward ptr so the last hit kept is the closest to ptr.
    always_comb begin
        idle_hit = 1'b0;
        idle_sel = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr) + k) % NUM_REQ;
            if (req_vld[idx]) begin
                idle_hit = 1'b1;
                idle_sel = IDW'(idx);
            end
        end
    end

    always_comb begin
        req_rdy = '0;
        sel     = '0;
        if (!rst) begin
            if (state == IDLE) begin
                sel = idle_sel;
                if (idle_hit) req_rdy[idle_sel] = 1'b1;
            end else begin
                sel = own;
                if (req_vld[own]) req_rdy[own] = 1'b1;
            end
        end
    end

    assign xfer     = |req_rdy;
    assign flit_sel = req_flit[int'(sel)*FLIT_WIDTH +: FLIT_WIDTH];
    assign ftype    = flit_sel[FLIT_WIDTH-1 -: 2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            own          <= '0;
            tcnt         <= '0;
            flit_tx      <= '0;
            flit_tx_vld  <= 1'b0;
            grant_id     <= '0;
            proto_err    <= 1'b0;
            lock_timeout <= 1'b0;
        end else begin
            flit_tx_vld  <= xfer;
            proto_err    <= 1'b0;
            lock_timeout <= 1'b0;
            if (xfer) begin
                flit_tx  <= flit_sel;
                grant_id <= sel;
            end
            case (state)
                IDLE: begin
                    if (xfer) begin
                        ptr <= next_idx(sel);
                        if (ftype == FT_HEAD) begin
                            state <= LOCKED;
                            own   <= sel;
                            tcnt  <= '0;
                        end else if (ftype != FT_SINGLE) begin
                            proto_err <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    // An owner transfer always beats an expiring timeout.
                    if (xfer) begin
                        tcnt <= '0;
                        if (ftype == FT_HEAD)
                            proto_err <= 1'b1;
                        else if (ftype == FT_TAIL || ftype == FT_SINGLE)
                            state <= IDLE;
                    end else if (tcnt == TW'(TIMEOUT)) begin
                        state        <= IDLE;
                        lock_timeout <= 1'b1;
                        ptr          <= next_idx(own);
                        tcnt         <= '0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flit_tx_arbiter.sv
// Directed plus randomized bench for flit_tx_arbiter against a queue-free integer reference model.
module tb_flit_tx_arbiter;

    localparam int N   = 4;
    localparam int W   = 128;
    localparam int TMO = 8;

    localparam logic [1:0] HEAD   = 2'b00;
    localparam logic [1:0] BODY   = 2'b01;
    localparam logic [1:0] TAIL   = 2'b10;
    localparam logic [1:0] SINGLE = 2'b11;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] req_flit;
    logic [N-1:0]   req_vld;
    logic [N-1:0]   req_rdy;
    logic [W-1:0]   flit_tx;
    logic           flit_tx_vld;
    logic [1:0]     grant_id;
    logic           proto_err;
    logic           lock_timeout;

    logic [W-1:0]   fl [N];

    int checks = 0;
    int passed = 0;

    // reference model state: owner -1 means nobody holds the link
    int         m_own  = -1;
    int         m_ptr  = 0;
    int         m_tcnt = 0;
    logic           e_vld  = 1'b0;
    logic [W-1:0]   e_flit = '0;
    logic [1:0]     e_gid  = '0;
    logic           e_perr = 1'b0;
    logic           e_to   = 1'b0;

    always #5 clk = ~clk;

    assign req_flit = {fl[3], fl[2], fl[1], fl[0]};

    flit_tx_arbiter #(.NUM_REQ(N), .FLIT_WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_flit     (req_flit),
        .req_vld      (req_vld),
        .req_rdy      (req_rdy),
        .flit_tx      (flit_tx),
        .flit_tx_vld  (flit_tx_vld),
        .grant_id     (grant_id),
        .proto_err    (proto_err),
        .lock_timeout (lock_timeout)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [W-1:0] mk(input logic [1:0] t);
        logic [W-1:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        r[W-1 -: 2] = t;
        return r;
    endfunction

    function automatic logic [N-1:0] model_rdy();
        logic [N-1:0] r;
        r = '0;
        if (rst) return r;
        if (m_own < 0) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (req_vld[i]) begin
                    r[i] = 1'b1;
                    break;
                end
            end
        end else if (req_vld[m_own]) begin
            r[m_own] = 1'b1;
        end
        return r;
    endfunction

    task automatic model_edge(input logic [N-1:0] er);
        int g;
        logic [1:0] t;
        if (rst) begin
            m_own = -1; m_ptr = 0; m_tcnt = 0;
            e_vld = 1'b0; e_flit = '0; e_gid = '0; e_perr = 1'b0; e_to = 1'b0;
            return;
        end
        e_vld = 1'b0; e_perr = 1'b0; e_to = 1'b0;
        g = -1;
        for (int i = 0; i < N; i++) if (er[i]) g = i;
        if (g >= 0) begin
            t      = fl[g][W-1 -: 2];
            e_vld  = 1'b1;
            e_flit = fl[g];
            e_gid  = 2'(g);
            if (m_own < 0) begin
                m_ptr = (g + 1) % N;
                if (t == HEAD) begin
                    m_own  = g;
                    m_tcnt = 0;
                end else if (t != SINGLE) begin
                    e_perr = 1'b1;
                end
            end else begin
                m_tcnt = 0;
                if (t == HEAD) e_perr = 1'b1;
                else if (t == TAIL || t == SINGLE) m_own = -1;
            end
        end else if (m_own >= 0) begin
            if (m_tcnt == TMO) begin
                e_to  = 1'b1;
                m_ptr = (m_own + 1) % N;
                m_own = -1;
            end else begin
                m_tcnt++;
            end
        end
    endtask

    // Inputs are set by the caller before this; one full clock cycle with model checks.
    task automatic cycle();
        logic [N-1:0] er;
        #1;
        er = model_rdy();
        chk("req_rdy", W'(req_rdy), W'(er));
        @(posedge clk);
        model_edge(er);
        @(negedge clk);
        chk("flit_tx_vld", W'(flit_tx_vld), W'(e_vld));
        chk("flit_tx", flit_tx, e_flit);
        chk("grant_id", W'(grant_id), W'(e_gid));
        chk("proto_err", W'(proto_err), W'(e_perr));
        chk("lock_timeout", W'(lock_timeout), W'(e_to));
    endtask

    initial begin
        logic [1:0] seq [5];
        seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rst = 1'b1;
        req_vld = '0;
        for (int i = 0; i < N; i++) fl[i] = mk(SINGLE);
        cycle();
        chk("reset_vld", W'(flit_tx_vld), W'(1'b0));
        chk("reset_gid", W'(grant_id), W'(2'd0));
        rst = 1'b0;

        // all four requesters with singles: strict rotation
        req_vld = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < N; i++) fl[i] = mk(SINGLE);
            cycle();
            chk("rr_seq", W'(grant_id), W'(seq[k]));
            chk("rr_vld", W'(flit_tx_vld), W'(1'b1));
        end

        // req2 packet while 0 and 1 keep offering singles
        req_vld = 4'b0100;
        fl[2] = mk(HEAD);
        cycle();
        chk("pkt_head", W'(grant_id), W'(2'd2));
        req_vld = 4'b0111;
        for (int k = 0; k < 4; k++) begin
            fl[0] = mk(SINGLE);
            fl[1] = mk(SINGLE);
            fl[2] = mk(k == 3 ? TAIL : BODY);
            cycle();
            chk("pkt_lock", W'(grant_id), W'(2'd2));
        end
        req_vld = 4'b1011;
        fl[3] = mk(SINGLE);
        cycle();
        chk("after_tail", W'(grant_id), W'(2'd3));
        chk("after_tail_vld", W'(flit_tx_vld), W'(1'b1));

        // req1 head, then silence until the lock times out
        req_vld = 4'b0010;
        fl[1] = mk(HEAD);
        cycle();
        req_vld = 4'b0101;
        fl[0] = mk(SINGLE);
        fl[2] = mk(SINGLE);
        for (int k = 1; k <= 9; k++) begin
            cycle();
            chk("tmo_pulse", W'(lock_timeout), W'(k == 9));
        end
        cycle();
        chk("tmo_next", W'(grant_id), W'(2'd2));

        // owner body on the very edge the counter hits TIMEOUT
        req_vld = 4'b0010;
        fl[1] = mk(HEAD);
        cycle();
        req_vld = 4'b0000;
        for (int k = 0; k < TMO; k++) cycle();
        req_vld = 4'b0010;
        fl[1] = mk(BODY);
        cycle();
        chk("tmo_race_to", W'(lock_timeout), W'(1'b0));
        chk("tmo_race_vld", W'(flit_tx_vld), W'(1'b1));
        fl[1] = mk(TAIL);
        cycle();

        // reset in the middle of a req3 packet
        req_vld = 4'b1000;
        fl[3] = mk(HEAD);
        cycle();
        fl[3] = mk(BODY);
        cycle();
        rst = 1'b1;
        req_vld = 4'b1111;
        #1;
        chk("rst_rdy", W'(req_rdy), W'(4'b0000));
        cycle();
        chk("rst_out", {flit_tx_vld, proto_err, lock_timeout, grant_id}, '0);
        chk("rst_flit", flit_tx, '0);
        rst = 1'b0;
        req_vld = 4'b1001;
        fl[0] = mk(SINGLE);
        cycle();
        chk("rst_winner", W'(grant_id), W'(2'd0));

        // framing errors: stray body in IDLE, repeated head while locked
        req_vld = 4'b0001;
        fl[0] = mk(BODY);
        cycle();
        chk("perr_body", W'(proto_err), W'(1'b1));
        fl[0] = mk(HEAD);
        cycle();
        fl[0] = mk(HEAD);
        cycle();
        chk("perr_head", W'(proto_err), W'(1'b1));
        req_vld = 4'b0011;
        fl[0] = mk(BODY);
        fl[1] = mk(SINGLE);
        cycle();
        chk("perr_keep", W'(grant_id), W'(2'd0));
        fl[0] = mk(TAIL);
        cycle();

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            req_vld = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                int r;
                r = $urandom_range(0, 7);
                fl[i] = mk(r < 3 ? BODY : (r < 5 ? HEAD : (r < 7 ? TAIL : SINGLE)));
            end
            cycle();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
